bus_cs_gen: RTL and testbench
=============================

BUS_CS_GEN -- requirements
Module: bus_cs_gen

Interface
REQ-001 Parameter ADDR_W, default 16: CPU address width.
REQ-002 Parameter PAGE_W, default 4: number of top address bits decoded (page number).
REQ-003 Parameter NUM_CS, default 6: number of chip-select channels.
REQ-004 Parameter WS_W, default 3: wait-state count width.
REQ-005 clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 addr  in  ADDR_W  CPU address, sampled when vld=1.
REQ-008 vld  in  1  access-start strobe, one cycle per bus access.
REQ-009 cfg_we  in  1  region-table write strobe.
REQ-010 cfg_idx  in  $clog2(NUM_CS)  region being written.
REQ-011 cfg_en / cfg_base / cfg_limit / cfg_ws  in  1 / PAGE_W / PAGE_W / WS_W  region enable, first page, last page (inclusive), wait states.
REQ-012 cs_n  out  NUM_CS  active-low chip selects, registered.
REQ-013 rdy  out  1  high = access completes this cycle / idle; low = CPU stalls.
REQ-014 miss  out  1  one-cycle pulse: access hit no enabled region.

Function
REQ-015 page = addr[ADDR_W-1 -: PAGE_W]; region i hits when en[i]=1 and base[i] <= page <= limit[i], unsigned compare.
REQ-016 Overlapping hits resolve to lowest index; at most one cs_n bit is ever low.
REQ-017 Region with base > limit never hits.
REQ-018 FSM states IDLE, WAIT, LAST; reset state IDLE.
REQ-019 IDLE + vld + hit: latch index and ws; ws=0 -> LAST, else -> WAIT with counter = ws.
REQ-020 WAIT: counter decrements each cycle; counter reaching 1 -> LAST.
REQ-021 LAST: one cycle, then IDLE.
REQ-022 cs_n[idx] low in every WAIT and LAST cycle, i.e. ws+1 cycles, starting one cycle after vld.
REQ-023 rdy low in WAIT, high in LAST and IDLE.
REQ-024 IDLE + vld + no hit: miss=1 next cycle for exactly one cycle; cs_n all high; rdy high; stay IDLE.
REQ-025 vld in WAIT or LAST is ignored: no queueing, no miss.
REQ-026 cfg_we writes entry cfg_idx at the clock edge; cfg_idx >= NUM_CS is ignored.
REQ-027 cfg_we and vld in the same cycle: the decode uses the pre-write table.
REQ-028 A table write during WAIT/LAST does not change the latched index or counter of the access in progress.

Reset
REQ-029 rst forces immediately: cs_n all 1, rdy=1, miss=0, state IDLE, counter 0, including mid-access.
REQ-030 Reset table (NUM_CS=6, PAGE_W=4): ch0 0x0-0x7 RAM; ch1 0xA; ch2 0xB; ch3 0xC; ch4 0xD PIA; ch5 0xE-0xF EEPROM; all enabled, ws=0.
REQ-031 Channels >= 6, or any PAGE_W other than 4, reset disabled with base=0, limit=0, ws=0.

Configuration
REQ-032 Macro BUS_CS_GEN_WAITSTATE_EN defined: cfg_ws stored and honoured per REQ-019..023.
REQ-033 Macro absent: no ws storage or counter; every hit goes IDLE->LAST (one-cycle cs_n); rdy tied high; cfg_ws ignored.

Structure
REQ-034 Package bus_cs_pkg holds the FSM state enum, the default region table constants (base, limit, en, ws per channel) and the channel-count type.
REQ-035 Sub-module bus_cs_region (one register entry plus range comparator) is instantiated NUM_CS times via generate; priority encode and FSM stay in bus_cs_gen.

Verification
REQ-036 After reset, vld with addr=0x1234 -> next cycle cs_n=6'b111110 for 1 cycle, rdy=1, miss=0.
REQ-037 vld addr=0x9000 -> miss=1 for one cycle, cs_n=6'b111111.
REQ-038 Write ch5 ws=3, vld addr=0xF000 -> cs_n[5] low 4 cycles, rdy low 3 then high; second vld during WAIT ignored.
REQ-039 Write ch1 base=0x0 limit=0xF -> vld addr=0x2000 selects ch0 (priority), addr=0x9000 selects ch1.
REQ-040 Assert rst during WAIT of a ws=5 access -> cs_n all high, rdy=1 same cycle; next vld addr=0xE000 decodes with reset table (ch5, ws=0).
REQ-041 Build without BUS_CS_GEN_WAITSTATE_EN, write ws=7 to ch4, vld addr=0xD010 -> cs_n[4] low 1 cycle, rdy constantly 1.

Source files
------------

// File: rtl/bus_cs_pkg.sv
// Shared types and reset-time region table for the chip-select generator.
package bus_cs_pkg;

   typedef enum logic [1:0] {StIdle, StWait, StLast} cs_state_e;

   localparam int unsigned DefNumCs = 6;
   localparam int unsigned DefPageW = 4;

   typedef logic [$clog2(DefNumCs)-1:0] cs_ch_t;

   // ch0 RAM, ch1..ch3 single pages, ch4 PIA, ch5 EEPROM
   localparam logic [DefPageW-1:0] DefBase  [DefNumCs] = '{4'h0, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE};
   localparam logic [DefPageW-1:0] DefLimit [DefNumCs] = '{4'h7, 4'hA, 4'hB, 4'hC, 4'hD, 4'hF};
   localparam bit                  DefEn    [DefNumCs] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
   localparam logic [7:0]          DefWs    [DefNumCs] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};

   function automatic logic [DefPageW-1:0] def_base(int unsigned ch);
      if (ch < DefNumCs) return DefBase[cs_ch_t'(ch)];
      return '0;
   endfunction

   function automatic logic [DefPageW-1:0] def_limit(int unsigned ch);
      if (ch < DefNumCs) return DefLimit[cs_ch_t'(ch)];
      return '0;
   endfunction

   function automatic bit def_en(int unsigned ch);
      if (ch < DefNumCs) return DefEn[cs_ch_t'(ch)];
      return 1'b0;
   endfunction

   function automatic logic [7:0] def_ws(int unsigned ch);
      if (ch < DefNumCs) return DefWs[cs_ch_t'(ch)];
      return '0;
   endfunction

endpackage

// File: rtl/bus_cs_gen_if.sv
// CPU bus and region-table config signals for bus_cs_gen.
interface bus_cs_gen_if #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned PAGE_W = 4,
   parameter int unsigned NUM_CS = 6,
   parameter int unsigned WS_W   = 3
) ();
   localparam int unsigned IDX_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

   logic [ADDR_W-1:0] addr;
   logic              vld;
   logic              cfg_we;
   logic [IDX_W-1:0]  cfg_idx;
   logic              cfg_en;
   logic [PAGE_W-1:0] cfg_base;
   logic [PAGE_W-1:0] cfg_limit;
   logic [WS_W-1:0]   cfg_ws;
   logic [NUM_CS-1:0] cs_n;
   logic              rdy;
   logic              miss;

   modport master (
      output addr, vld, cfg_we, cfg_idx, cfg_en, cfg_base, cfg_limit, cfg_ws,
      input  cs_n, rdy, miss
   );

   modport slave (
      input  addr, vld, cfg_we, cfg_idx, cfg_en, cfg_base, cfg_limit, cfg_ws,
      output cs_n, rdy, miss
   );
endinterface

// File: rtl/bus_cs_region.sv
// One region-table entry plus its inclusive page-range comparator.
// Wait-state storage exists only with BUS_CS_GEN_WAITSTATE_EN.
module bus_cs_region #(
   parameter int unsigned       PAGE_W    = 4,
   parameter int unsigned       WS_W      = 3,
   parameter bit                RST_EN    = 1'b0,
   parameter logic [PAGE_W-1:0] RST_BASE  = '0,
   parameter logic [PAGE_W-1:0] RST_LIMIT = '0,
   parameter logic [WS_W-1:0]   RST_WS    = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic              cfg_en,
   input  logic [PAGE_W-1:0] cfg_base,
   input  logic [PAGE_W-1:0] cfg_limit,
`ifdef BUS_CS_GEN_WAITSTATE_EN
   input  logic [WS_W-1:0]   cfg_ws,
   output logic [WS_W-1:0]   ws,
`endif
   input  logic [PAGE_W-1:0] page,
   output logic              hit
);

   logic              en_q;
   logic [PAGE_W-1:0] base_q;
   logic [PAGE_W-1:0] limit_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         en_q    <= RST_EN;
         base_q  <= RST_BASE;
         limit_q <= RST_LIMIT;
      end else if (we) begin
         en_q    <= cfg_en;
         base_q  <= cfg_base;
         limit_q <= cfg_limit;
      end
   end

`ifdef BUS_CS_GEN_WAITSTATE_EN
   logic [WS_W-1:0] ws_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ws_q <= RST_WS;
      end else if (we) begin
         ws_q <= cfg_ws;
      end
   end

   assign ws = ws_q;
`endif

   // base > limit can never satisfy both bounds, so such a region is inert
   assign hit = en_q && (base_q <= page) && (page <= limit_q);

endmodule

// File: rtl/bus_cs_gen.sv
// Page-decoded chip-select generator with priority resolve and optional wait states.
// Wait states are built only when BUS_CS_GEN_WAITSTATE_EN is defined.
module bus_cs_gen
   import bus_cs_pkg::*;
#(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned PAGE_W = 4,
   parameter int unsigned NUM_CS = 6,
   parameter int unsigned WS_W   = 3
) (
   input  logic         clk,
   input  logic         rst,
   bus_cs_gen_if.slave  bus
);

   localparam int unsigned IDX_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
   localparam bit          USE_DEF = (PAGE_W == DefPageW);

   logic [PAGE_W-1:0] page;
   logic              unused_addr;

   assign page        = bus.addr[ADDR_W-1 -: PAGE_W];
   assign unused_addr = ^bus.addr[ADDR_W-PAGE_W-1:0];

   logic [NUM_CS-1:0] hit;
`ifdef BUS_CS_GEN_WAITSTATE_EN
   logic [WS_W-1:0]   ws [NUM_CS];
   logic [WS_W-1:0]   ws_sel;
`else
   logic              unused_ws;
   assign unused_ws = ^bus.cfg_ws;
`endif

   for (genvar i = 0; i < NUM_CS; i++) begin : g_region
      bus_cs_region #(
         .PAGE_W   (PAGE_W),
         .WS_W     (WS_W),
         .RST_EN   (USE_DEF && def_en(i)),
         .RST_BASE (USE_DEF ? PAGE_W'(def_base(i)) : '0),
         .RST_LIMIT(USE_DEF ? PAGE_W'(def_limit(i)) : '0),
         .RST_WS   (USE_DEF ? WS_W'(def_ws(i)) : '0)
      ) u_region (
         .clk      (clk),
         .rst      (rst),
         .we       (bus.cfg_we && (bus.cfg_idx == IDX_W'(i))),
         .cfg_en   (bus.cfg_en),
         .cfg_base (bus.cfg_base),
         .cfg_limit(bus.cfg_limit),
`ifdef BUS_CS_GEN_WAITSTATE_EN
         .cfg_ws   (bus.cfg_ws),
         .ws       (ws[i]),
`endif
         .page     (page),
         .hit      (hit[i])
      );
   end

   logic             hit_any;
   logic [IDX_W-1:0] hit_idx;

   // Scan high to low so the lowest matching index wins
   always_comb begin
      hit_any = 1'b0;
      hit_idx = '0;
`ifdef BUS_CS_GEN_WAITSTATE_EN
      ws_sel  = '0;
`endif
      for (int i = NUM_CS - 1; i >= 0; i--) begin
         if (hit[i]) begin
            hit_any = 1'b1;
            hit_idx = IDX_W'(i);
`ifdef BUS_CS_GEN_WAITSTATE_EN
            ws_sel  = ws[i];
`endif
         end
      end
   end

   cs_state_e         state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              miss_q, miss_d;
   logic [NUM_CS-1:0] cs_n_q, cs_n_d;
`ifdef BUS_CS_GEN_WAITSTATE_EN
   logic [WS_W-1:0]   cnt_q, cnt_d;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         idx_q   <= '0;
         miss_q  <= 1'b0;
         cs_n_q  <= '1;
`ifdef BUS_CS_GEN_WAITSTATE_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         miss_q  <= miss_d;
         cs_n_q  <= cs_n_d;
`ifdef BUS_CS_GEN_WAITSTATE_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   // Table writes only touch the region entries, never idx/cnt of a running access
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      miss_d  = 1'b0;
`ifdef BUS_CS_GEN_WAITSTATE_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         StIdle: begin
            if (bus.vld) begin
               if (hit_any) begin
                  idx_d = hit_idx;
`ifdef BUS_CS_GEN_WAITSTATE_EN
                  if (ws_sel == '0) begin
                     state_d = StLast;
                  end else begin
                     state_d = StWait;
                     cnt_d   = ws_sel;
                  end
`else
                  state_d = StLast;
`endif
               end else begin
                  miss_d = 1'b1;
               end
            end
         end
         StWait: begin
`ifdef BUS_CS_GEN_WAITSTATE_EN
            cnt_d = cnt_q - WS_W'(1);
            if (cnt_q == WS_W'(1)) begin
               state_d = StLast;
            end
`else
            state_d = StIdle;
`endif
         end
         StLast:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      cs_n_d = '1;
      for (int i = 0; i < NUM_CS; i++) begin
         if ((state_d != StIdle) && (idx_d == IDX_W'(i))) begin
            cs_n_d[i] = 1'b0;
         end
      end
   end

   assign bus.cs_n = cs_n_q;
   assign bus.miss = miss_q;
`ifdef BUS_CS_GEN_WAITSTATE_EN
   assign bus.rdy  = (state_q != StWait);
`else
   assign bus.rdy  = 1'b1;
`endif

endmodule

// File: tb/tb_bus_cs_gen.sv
// Scoreboard bench for bus_cs_gen: driver predicts access outcomes from a table model,
// monitor measures each chip-select burst or miss pulse and compares.
module tb_bus_cs_gen;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned PAGE_W = 4;
   localparam int unsigned NUM_CS = 6;
   localparam int unsigned WS_W   = 3;
`ifdef BUS_CS_GEN_WAITSTATE_EN
   localparam bit WsEn = 1'b1;
`else
   localparam bit WsEn = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bus_cs_gen_if #(.ADDR_W(ADDR_W), .PAGE_W(PAGE_W), .NUM_CS(NUM_CS), .WS_W(WS_W)) bus ();

   bus_cs_gen #(.ADDR_W(ADDR_W), .PAGE_W(PAGE_W), .NUM_CS(NUM_CS), .WS_W(WS_W)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int checks   = 0;
   int failures = 0;

   typedef struct {
      bit is_miss;
      int ch;
      int len;
   } exp_t;

   exp_t exp_q[$];

   bit m_en    [NUM_CS];
   int m_base  [NUM_CS];
   int m_limit [NUM_CS];
   int m_ws    [NUM_CS];
   int busy;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic void model_reset();
      int b[NUM_CS] = '{0, 10, 11, 12, 13, 14};
      int l[NUM_CS] = '{7, 10, 11, 12, 13, 15};
      for (int i = 0; i < NUM_CS; i++) begin
         m_en[i] = 1'b1; m_base[i] = b[i]; m_limit[i] = l[i]; m_ws[i] = 0;
      end
   endfunction

   function automatic int model_decode(input int pg);
      for (int i = 0; i < NUM_CS; i++) begin
         if (m_en[i] && m_base[i] <= pg && pg <= m_limit[i]) return i;
      end
      return -1;
   endfunction

   // One bus cycle: drive inputs, predict outcome, then advance past the clock edge
   task automatic step(input bit v, input logic [15:0] a, input bit we, input int idx,
                       input bit en, input int base, input int limit, input int ws);
      bit accept = 1'b0;
      int len = 0;
      int ch;
      bus.vld       = v;
      bus.addr      = a;
      bus.cfg_we    = we;
      bus.cfg_idx   = 3'(idx);
      bus.cfg_en    = en;
      bus.cfg_base  = 4'(base);
      bus.cfg_limit = 4'(limit);
      bus.cfg_ws    = 3'(ws);
      if (v && busy == 0) begin
         ch = model_decode(int'(a[15:12]));
         if (ch < 0) begin
            exp_q.push_back('{is_miss: 1'b1, ch: -1, len: 0});
         end else begin
            len = (WsEn ? m_ws[ch] : 0) + 1;
            exp_q.push_back('{is_miss: 1'b0, ch: ch, len: len});
            accept = 1'b1;
         end
      end
      if (we && idx < NUM_CS) begin
         m_en[idx] = en; m_base[idx] = base; m_limit[idx] = limit; m_ws[idx] = ws;
      end
      @(posedge clk);
      if (accept) busy = len;
      else if (busy > 0) busy--;
      #1;
      bus.vld    = 1'b0;
      bus.cfg_we = 1'b0;
   endtask

   task automatic access(input logic [15:0] a);
      step(1'b1, a, 1'b0, 0, 1'b0, 0, 0, 0);
   endtask

   task automatic cfg(input int idx, input bit en, input int base, input int limit, input int ws);
      step(1'b0, 16'h0, 1'b1, idx, en, base, limit, ws);
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 16'h0, 1'b0, 0, 1'b0, 0, 0, 0);
   endtask

   task automatic reset_now(input string tag);
      rst        = 1'b1;
      bus.vld    = 1'b0;
      bus.cfg_we = 1'b0;
      exp_q.delete();
      busy = 0;
      model_reset();
      #1;
      check({tag, "_cs_n"}, int'(bus.cs_n), 63);
      check({tag, "_rdy"}, int'(bus.rdy), 1);
      check({tag, "_miss"}, int'(bus.miss), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   bit in_acc = 1'b0;
   int acc_ch, acc_len, acc_rdy_low;
   int nlow, lch;
   exp_t e;

   always @(negedge clk) begin
      if (rst) begin
         in_acc = 1'b0;
      end else begin
         nlow = $countones(~bus.cs_n);
         check("cs_n_onehot", int'(nlow > 1), 0);
         lch = -1;
         for (int i = 0; i < NUM_CS; i++) if (!bus.cs_n[i]) lch = i;
         if (bus.miss) begin
            check("miss_cs_n", int'(bus.cs_n), 63);
            if (exp_q.size() == 0) begin
               check("miss_unexpected", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("miss_kind", int'(e.is_miss), 1);
            end
         end
         if (nlow > 0) begin
            if (!in_acc) begin
               in_acc = 1'b1; acc_ch = lch; acc_len = 1; acc_rdy_low = int'(!bus.rdy);
            end else begin
               check("cs_ch_stable", lch, acc_ch);
               acc_len++;
               acc_rdy_low += int'(!bus.rdy);
            end
         end else begin
            check("rdy_idle", int'(bus.rdy), 1);
            if (in_acc) begin
               in_acc = 1'b0;
               if (exp_q.size() == 0) begin
                  check("access_unexpected", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  check("access_kind", int'(e.is_miss), 0);
                  check("access_ch", acc_ch, e.ch);
                  check("access_len", acc_len, e.len);
                  check("access_rdy_low", acc_rdy_low, e.len - 1);
               end
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      bus.vld = 1'b0; bus.addr = '0; bus.cfg_we = 1'b0; bus.cfg_idx = '0;
      bus.cfg_en = 1'b0; bus.cfg_base = '0; bus.cfg_limit = '0; bus.cfg_ws = '0;
      busy = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset_cs_n", int'(bus.cs_n), 63);
      check("reset_rdy", int'(bus.rdy), 1);
      check("reset_miss", int'(bus.miss), 0);
      rst = 1'b0;

      access(16'h1234); idle(2);                 // RAM ch0
      access(16'h9000); idle(2);                 // unmapped page
      cfg(5, 1'b1, 14, 15, 3);
      access(16'hF000);
      access(16'h1234);                          // issued mid-access, must be dropped
      idle(6);
      access(16'h8000); idle(2);
      cfg(1, 1'b1, 0, 15, 0);
      access(16'h2000); idle(2);                 // overlap, ch0 wins
      access(16'h9000); idle(2);                 // only ch1 covers page 9
      // disable ch1 in the same cycle as a decode: old table applies
      step(1'b1, 16'h9000, 1'b1, 1, 1'b0, 0, 15, 0); idle(2);
      access(16'h9000); idle(2);
      cfg(6, 1'b1, 8, 9, 0); cfg(7, 1'b1, 8, 9, 0);
      access(16'h8000); idle(2);
      cfg(2, 1'b1, 12, 3, 0);                    // base > limit
      access(16'hB000); idle(2);

      cfg(5, 1'b1, 14, 15, 5);
      access(16'hF000);
      reset_now("midacc_rst");
      access(16'hE000); idle(2);
      cfg(4, 1'b1, 13, 13, 7);
      access(16'hD010); idle(10);

      for (int n = 0; n < 600; n++) begin
         step(1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 7) == 0),
              int'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
              int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 7)));
      end
      idle(12);
      check("queue_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
